mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the register bank.
- Consumes the two register read ports (rs to OperandA, rt to OperandB) for MULT/MULTU/DIV/DIVU.
- Writes results into HI/LO, which MFHI/MFLO route back to the register bank write port.
- Multi-cycle; the pipeline/control stalls on Busy.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_iter_step.sv | 37 +++
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op and state encodings and the default operand width.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
// Zero latency; no flow control.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              mul_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic            ge;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : {(DATA_W+1){1'b0}});
    shifted = {hi_i, lo_i[DATA_W-1]};
    ge      = shifted >= {1'b0, operand_i};
    if (mul_i) begin
      // Multiplier bits are consumed from lo while product bits enter from the top.
      hi_o = sum[DATA_W:1];
      lo_o = {sum[0], lo_i[DATA_W-1:1]};
    end else if (ge) begin
      hi_o = DATA_W'(shifted - {1'b0, operand_i});
      lo_o = {lo_i[DATA_W-2:0], 1'b1};
    end else begin
      hi_o = shifted[DATA_W-1:0];
      lo_o = {lo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; result DATA_W+1 edges after Start, caller stalls on Busy.
// Optional macro MDU_EARLY_OUT_EN: trivial operations skip RUN and finish in two edges.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  input  logic              WriteHi,
  input  logic              WriteLo,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam int CNT_W = $clog2(DATA_W);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              div_zero_q;
  logic              done_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] acc_hi_q;
  logic [DATA_W-1:0] acc_lo_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] acc_hi_d;
  logic [DATA_W-1:0] acc_lo_d;

  logic                is_div;
  logic                a_neg;
  logic                b_neg;
  logic                early;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  always_comb begin
    is_div = Op[1];
    a_neg  = op_is_signed(Op) & OperandA[DATA_W-1];
    b_neg  = op_is_signed(Op) & OperandB[DATA_W-1];
    a_mag  = a_neg ? -OperandA : OperandA;
    b_mag  = b_neg ? -OperandB : OperandB;
  end

`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    if (is_div) early = (b_mag != '0) && (a_mag < b_mag);
    else        early = (a_mag == '0) || (b_mag == '0);
  end
`else
  assign early = 1'b0;
`endif

  mdu_iter_step #(.DATA_W(DATA_W)) u_step (
    .mul_i     (~is_div_q),
    .hi_i      (acc_hi_q),
    .lo_i      (acc_lo_q),
    .operand_i (opnd_q),
    .hi_o      (acc_hi_d),
    .lo_o      (acc_lo_d)
  );

  // Divide-by-zero leaves |A| in the remainder, so the signed fix restores A.
  always_comb begin
    prod_fix = {acc_hi_q, acc_lo_q};
    if (neg_res_q) prod_fix = -prod_fix;
    if (is_div_q) begin
      fix_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
      fix_lo = div_zero_q ? {DATA_W{1'b1}} : (neg_res_q ? -acc_lo_q : acc_lo_q);
    end else begin
      fix_hi = prod_fix[2*DATA_W-1:DATA_W];
      fix_lo = prod_fix[DATA_W-1:0];
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (WriteHi) hi_q <= WriteData;
          if (WriteLo) lo_q <= WriteData;
          if (Start) begin
            is_div_q   <= is_div;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= is_div && (OperandB == '0);
            opnd_q     <= is_div ? b_mag : a_mag;
            cnt_q      <= '0;
            if (early) begin
              acc_hi_q <= is_div ? a_mag : '0;
              acc_lo_q <= '0;
              state_q  <= FIX;
            end else begin
              acc_hi_q <= '0;
              acc_lo_q <= is_div ? a_mag : b_mag;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: results, latency, Busy window, MTHI/MTLO and reset abort.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         WriteHi = 1'b0;
  logic         WriteLo = 1'b0;
  logic [W-1:0] WriteData = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int n_chk = 0;
  int n_pass = 0;

  mult_div_unit #(.DATA_W(W)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .WriteHi   (WriteHi),
    .WriteLo   (WriteLo),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present a request for one edge, then scramble the operand inputs.
  task automatic kick(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clock);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0; OperandA = ~a; OperandB = ~b ^ 32'h5A5A_0F0F;
  endtask

  // k = edges after the current point until Done is seen; busy = Busy cycles seen on the way.
  task automatic wait_done(input string tag, output int k, output int busy);
    bit got;
    got = 0; k = 0; busy = 0;
    for (int i = 1; i <= 200 && !got; i++) begin
      if (Busy) busy++;
      @(posedge Clock); #1;
      if (Done) begin got = 1; k = i; end
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int exp_lat);
    int k, busy;
    kick(op, a, b);
    wait_done(tag, k, busy);
    check({tag, "_lat"}, k + 1, exp_lat);
    check({tag, "_busy_in_done"}, {31'd0, Busy}, 32'd0);
    check({tag, "_hi"}, Hi, exp_hi);
    check({tag, "_lo"}, Lo, exp_lo);
    if (exp_lat == W + 2) check({tag, "_busy_cycles"}, busy, W + 1);
    @(posedge Clock); #1;
    check({tag, "_done_1cyc"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    int k, busy, seen;

    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, W + 2);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, W + 2);
    run_op("mult_negneg", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0015, W + 2);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, W + 2);
    run_op("divu_zero", OP_DIVU, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, W + 2);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, W + 2);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W + 2);

    // Second Start and MTHI while busy are both dropped.
    kick(OP_MULTU, 32'd5, 32'd7);
    repeat (9) @(posedge Clock);
    @(negedge Clock);
    Start = 1'b1; Op = OP_DIVU; OperandA = 32'd1; OperandB = 32'd1;
    WriteHi = 1'b1; WriteData = 32'h0000_AAAA;
    @(posedge Clock); #1;
    Start = 1'b0; WriteHi = 1'b0;
    wait_done("busy_ign", k, busy);
    check("busy_ign_lat", k + 11, W + 2);
    check("busy_ign_hi", Hi, 32'd0);
    check("busy_ign_lo", Lo, 32'd35);
    @(posedge Clock); #1;
    check("busy_ign_no_restart", {31'd0, Busy}, 32'd0);

    @(negedge Clock);
    WriteLo = 1'b1; WriteData = 32'h0000_1234;
    @(posedge Clock); #1;
    WriteLo = 1'b0;
    check("mtlo_lo", Lo, 32'h0000_1234);
    check("mtlo_hi_kept", Hi, 32'd0);

    // MTLO on the Start edge lands, then the result replaces it.
    @(negedge Clock);
    Op = OP_MULTU; OperandA = 32'd2; OperandB = 32'd3; Start = 1'b1;
    WriteLo = 1'b1; WriteData = 32'h0000_0055;
    @(posedge Clock); #1;
    Start = 1'b0; WriteLo = 1'b0;
    check("start_wr_lands", Lo, 32'h0000_0055);
    wait_done("start_wr", k, busy);
    check("start_wr_lo", Lo, 32'd6);

    @(negedge Clock);
    WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hCAFE_BEEF;
    @(posedge Clock); #1;
    WriteHi = 1'b0; WriteLo = 1'b0;
    check("mthilo_hi", Hi, 32'hCAFE_BEEF);
    check("mthilo_lo", Lo, 32'hCAFE_BEEF);

    // Reset mid-operation discards everything.
    kick(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", Hi, 32'd0);
    check("abort_lo", Lo, 32'd0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      if (Done) seen++;
    end
    check("abort_no_done", seen, 0);

`ifdef MDU_EARLY_OUT_EN
    run_op("early_divu", OP_DIVU, 32'd3, 32'd10, 32'd3, 32'd0, 2);
    run_op("early_div_neg", OP_DIV, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 32'd0, 2);
    run_op("early_mult0", OP_MULT, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 2);
`endif
    run_op("post_abort", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, W + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
